// File: rtl/point_buf_pkg.sv
// Shared types for the centroid replay buffer: replay FSM states and the
// default-width point payload with pack/unpack helpers.
package point_buf_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        WAIT    = 2'd2,
        PRESENT = 2'd3
    } replay_state_t;

    localparam int unsigned DEF_X_W  = 9;
    localparam int unsigned DEF_Y_W  = 8;
    localparam int unsigned DEF_Z_W  = 9;
    localparam int unsigned DEF_PT_W = DEF_X_W + DEF_Y_W + DEF_Z_W;

    typedef struct packed {
        logic [DEF_X_W-1:0] x;
        logic [DEF_Y_W-1:0] y;
        logic [DEF_Z_W-1:0] z;
    } point_t;

    function automatic logic [DEF_PT_W-1:0] pack_point(input point_t p);
        return {p.x, p.y, p.z};
    endfunction

    function automatic point_t unpack_point(input logic [DEF_PT_W-1:0] v);
        point_t p;
        p.x = v[DEF_PT_W-1 -: DEF_X_W];
        p.y = v[DEF_Y_W+DEF_Z_W-1 -: DEF_Y_W];
        p.z = v[DEF_Z_W-1:0];
        return p;
    endfunction

endpackage

// File: rtl/point_ram.sv
// Simple dual-port point store: one write port, one read port, read-first,
// RD_LAT (1 or 2) output register stages.
module point_ram #(
    parameter int unsigned W      = 26,
    parameter int unsigned DEPTH  = 2250,
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rd0_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Non-blocking read alongside the write gives old data on an address collision.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd0_q <= mem[rd_addr];
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic [W-1:0] rd1_q;
        always_ff @(posedge clk) begin
            rd1_q <= rd0_q;
        end
        assign rd_data = rd1_q;
    end else begin : g_lat1
        assign rd_data = rd0_q;
    end

endmodule

// File: rtl/point_replay_buffer.sv
// Circular store of tracked 3-D centroids with continuous oldest-first replay
// over a valid/ready handshake, sweep first/last markers and a clear command.
module point_replay_buffer
    import point_buf_pkg::*;
#(
    parameter int unsigned X_W    = 9,
    parameter int unsigned Y_W    = 8,
    parameter int unsigned Z_W    = 9,
    parameter int unsigned DEPTH  = 2250,
    parameter int unsigned RD_LAT = 2
) (
    input  logic                       clk_camera,
    input  logic                       sys_rst,
    input  logic                       draw_mode,
    input  logic                       clear_in,
    input  logic                       in_valid,
    input  logic [X_W-1:0]             in_x,
    input  logic [Y_W-1:0]             in_y,
    input  logic [Z_W-1:0]             in_z,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [X_W-1:0]             out_x,
    output logic [Y_W-1:0]             out_y,
    output logic [Z_W-1:0]             out_z,
    output logic                       out_first,
    output logic                       out_last,
    output logic [$clog2(DEPTH+1)-1:0] num_points,
    output logic                       full,
    output logic [$clog2(DEPTH)-1:0]   wr_addr
);

    localparam int unsigned PT_W = X_W + Y_W + Z_W;
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CW   = $clog2(DEPTH + 1);

    function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
        return (a == AW'(DEPTH - 1)) ? '0 : a + AW'(1);
    endfunction

    replay_state_t   state_q, state_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [CW-1:0]   num_q, num_d;
    logic            wrapped_q, wrapped_d;
    logic            full_q, full_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   len_q, len_d;
    logic [CW-1:0]   idx_q, idx_d;
    logic            wcnt_q, wcnt_d;
    logic            restart_q, restart_d;
    logic            mode_q, mode_d;
    logic            out_valid_q, out_valid_d;
    logic [PT_W-1:0] data_q, data_d;
    logic            first_q, first_d;
    logic            last_q, last_d;

    logic            wr_en;
    logic            rd_en;
    logic [PT_W-1:0] rd_data;

    assign wr_en = draw_mode && in_valid && !clear_in;

    point_ram #(
        .W      (PT_W),
        .DEPTH  (DEPTH),
        .RD_LAT (RD_LAT),
        .AW     (AW)
    ) u_ram (
        .clk     (clk_camera),
        .wr_en   (wr_en),
        .wr_addr (wr_addr_q),
        .wr_data ({in_x, in_y, in_z}),
        .rd_en   (rd_en),
        .rd_addr (ptr_q),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d     = state_q;
        wr_addr_d   = wr_addr_q;
        num_d       = num_q;
        wrapped_d   = wrapped_q;
        ptr_d       = ptr_q;
        len_d       = len_q;
        idx_d       = idx_q;
        wcnt_d      = wcnt_q;
        restart_d   = restart_q;
        mode_d      = draw_mode;
        out_valid_d = out_valid_q;
        data_d      = data_q;
        first_d     = first_q;
        last_d      = last_q;
        rd_en       = 1'b0;

        if (wr_en) begin
            wr_addr_d = addr_inc(wr_addr_q);
            if (wr_addr_q == AW'(DEPTH - 1)) begin
                wrapped_d = 1'b1;
            end
            if (num_q != CW'(DEPTH)) begin
                num_d = num_q + CW'(1);
            end
        end

        if (draw_mode != mode_q) begin
            restart_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                // Snapshot start/length so writes during the sweep land in the next one.
                if (num_q != '0) begin
                    ptr_d     = wrapped_q ? wr_addr_q : '0;
                    len_d     = num_q;
                    idx_d     = '0;
                    restart_d = 1'b0;
                    state_d   = READ;
                end
            end
            READ: begin
                rd_en   = 1'b1;
                ptr_d   = addr_inc(ptr_q);
                idx_d   = idx_q + CW'(1);
                wcnt_d  = 1'b0;
                state_d = WAIT;
            end
            WAIT: begin
                if (wcnt_q == 1'(RD_LAT - 1)) begin
                    data_d      = rd_data;
                    first_d     = (idx_q == CW'(1));
                    last_d      = (idx_q == len_q);
                    out_valid_d = 1'b1;
                    state_d     = PRESENT;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            PRESENT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (restart_q || (idx_q == len_q)) begin
                        restart_d = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Clear wins over everything, including a same-cycle write and an in-flight read.
        if (clear_in) begin
            wr_addr_d   = '0;
            num_d       = '0;
            wrapped_d   = 1'b0;
            out_valid_d = 1'b0;
            first_d     = 1'b0;
            last_d      = 1'b0;
            restart_d   = 1'b0;
            state_d     = IDLE;
        end

        full_d = (num_d == CW'(DEPTH));
    end

    always_ff @(posedge clk_camera or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            wr_addr_q   <= '0;
            num_q       <= '0;
            wrapped_q   <= 1'b0;
            full_q      <= 1'b0;
            ptr_q       <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            wcnt_q      <= 1'b0;
            restart_q   <= 1'b0;
            mode_q      <= 1'b0;
            out_valid_q <= 1'b0;
            data_q      <= '0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_addr_q   <= wr_addr_d;
            num_q       <= num_d;
            wrapped_q   <= wrapped_d;
            full_q      <= full_d;
            ptr_q       <= ptr_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            wcnt_q      <= wcnt_d;
            restart_q   <= restart_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
            first_q     <= first_d;
            last_q      <= last_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_x      = data_q[PT_W-1 -: X_W];
    assign out_y      = data_q[Y_W+Z_W-1 -: Y_W];
    assign out_z      = data_q[Z_W-1:0];
    assign out_first  = first_q;
    assign out_last   = last_q;
    assign num_points = num_q;
    assign full       = full_q;
    assign wr_addr    = wr_addr_q;

endmodule

// File: tb/tb_point_replay_buffer.sv
// Randomized bench for point_replay_buffer: a queue of retained points models
// the buffer, and each replay sweep must reproduce that queue oldest-first.
module tb_point_replay_buffer;

    localparam int unsigned X_W    = 9;
    localparam int unsigned Y_W    = 8;
    localparam int unsigned Z_W    = 9;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned RD_LAT = 2;
    localparam int unsigned PT_W   = X_W + Y_W + Z_W;
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned CW     = $clog2(DEPTH + 1);

    logic           clk;
    logic           rst;
    logic           draw_mode;
    logic           clear_in;
    logic           in_valid;
    logic [X_W-1:0] in_x;
    logic [Y_W-1:0] in_y;
    logic [Z_W-1:0] in_z;
    logic           out_valid;
    logic           out_ready;
    logic [X_W-1:0] out_x;
    logic [Y_W-1:0] out_y;
    logic [Z_W-1:0] out_z;
    logic           out_first;
    logic           out_last;
    logic [CW-1:0]  num_points;
    logic           full;
    logic [AW-1:0]  wr_addr;

    point_replay_buffer #(
        .X_W(X_W), .Y_W(Y_W), .Z_W(Z_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)
    ) dut (
        .clk_camera (clk),
        .sys_rst    (rst),
        .draw_mode  (draw_mode),
        .clear_in   (clear_in),
        .in_valid   (in_valid),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_z       (in_z),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_z      (out_z),
        .out_first  (out_first),
        .out_last   (out_last),
        .num_points (num_points),
        .full       (full),
        .wr_addr    (wr_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int checks = 0;
    int errors = 0;

    // Reference model: the most recent DEPTH accepted points, oldest first.
    logic [PT_W-1:0] model_q[$];
    int unsigned     wr_total = 0;

    task automatic model_clear();
        model_q.delete();
        wr_total = 0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear_in = 1'b1;
        @(negedge clk);
        clear_in = 1'b0;
        model_clear();
    endtask

    task automatic write_one(input logic [X_W-1:0] x, input logic [Y_W-1:0] y,
                             input logic [Z_W-1:0] z);
        @(negedge clk);
        in_valid = 1'b1;
        in_x = x;
        in_y = y;
        in_z = z;
        model_q.push_back({x, y, z});
        if (model_q.size() > DEPTH) void'(model_q.pop_front());
        wr_total++;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic write_random(input int n);
        for (int i = 0; i < n; i++) begin
            write_one(X_W'($urandom), Y_W'($urandom), Z_W'($urandom));
        end
    endtask

    task automatic wait_beat(output logic [PT_W-1:0] d, output logic f, output logic l,
                             output int unsigned t, output bit ok);
        ok = 1'b0;
        d  = '0;
        f  = 1'b0;
        l  = 1'b0;
        t  = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                d  = {out_x, out_y, out_z};
                f  = out_first;
                l  = out_last;
                t  = cyc;
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Leave DRAW while a beat is held, then accept it so the next beat opens a fresh sweep.
    task automatic sync_review(input string tag);
        logic [PT_W-1:0] d;
        logic f, l;
        int unsigned t;
        bit ok;
        repeat (10) @(negedge clk);
        draw_mode = 1'b0;
        wait_beat(d, f, l, t, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_sync: out_valid never rose within 200 cycles", tag);
        end
        out_ready = 1'b1;
    endtask

    task automatic check_replay(input int sweeps, input string tag);
        logic [PT_W-1:0] d;
        logic f, l;
        int unsigned t, t_prev;
        bit ok;
        int n;
        n = model_q.size();
        checks++;
        if (num_points !== CW'(n) || full !== (n == DEPTH) || wr_addr !== AW'(wr_total % DEPTH)) begin
            errors++;
            $display("FAIL %s_counts: num=%0d full=%0d wr_addr=%0d, expected num=%0d full=%0d wr_addr=%0d",
                     tag, num_points, full, wr_addr, n, (n == DEPTH), wr_total % DEPTH);
        end
        t_prev = 0;
        for (int s = 0; s < sweeps; s++) begin
            for (int i = 0; i < n; i++) begin
                wait_beat(d, f, l, t, ok);
                checks++;
                if (!ok) begin
                    errors++;
                    $display("FAIL %s_timeout: sweep %0d beat %0d never arrived", tag, s, i);
                    return;
                end
                if (d !== model_q[i] || f !== (i == 0) || l !== (i == n - 1)) begin
                    errors++;
                    $display("FAIL %s_beat: sweep %0d beat %0d got data=%h first=%0d last=%0d, expected data=%h first=%0d last=%0d",
                             tag, s, i, d, f, l, model_q[i], (i == 0), (i == n - 1));
                end
                if (i > 0) begin
                    checks++;
                    if (t - t_prev != RD_LAT + 2) begin
                        errors++;
                        $display("FAIL %s_spacing: sweep %0d beat %0d came %0d cycles after previous, expected %0d",
                                 tag, s, i, t - t_prev, RD_LAT + 2);
                    end
                end
                t_prev = t;
            end
        end
    endtask

    task automatic prepare(input string tag);
        out_ready = 1'b0;
        draw_mode = 1'b1;
        do_clear();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || num_points !== '0 || full !== 1'b0 || wr_addr !== '0 ||
            out_first !== 1'b0 || out_last !== 1'b0 || {out_x, out_y, out_z} !== '0) begin
            errors++;
            $display("FAIL reset_state: valid=%0d num=%0d full=%0d wr_addr=%0d first=%0d last=%0d data=%h, expected all zero",
                     out_valid, num_points, full, wr_addr, out_first, out_last, {out_x, out_y, out_z});
        end
        begin
            int bad = 0;
            repeat (20) begin
                @(negedge clk);
                if (out_valid !== 1'b0) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL reset_idle: out_valid high on %0d cycles, expected 0", bad);
            end
        end
    endtask

    task automatic test_basic();
        prepare("basic");
        write_one(9'd1, 8'd1, 9'd1);
        write_one(9'd2, 8'd2, 9'd2);
        write_one(9'd3, 8'd3, 9'd3);
        sync_review("basic");
        check_replay(3, "basic");
    endtask

    task automatic test_wrap();
        prepare("wrap");
        write_random(10);
        repeat (2) @(negedge clk);
        checks++;
        if (num_points !== CW'(8) || full !== 1'b1 || wr_addr !== AW'(2)) begin
            errors++;
            $display("FAIL wrap_counts: num=%0d full=%0d wr_addr=%0d, expected num=8 full=1 wr_addr=2",
                     num_points, full, wr_addr);
        end
        sync_review("wrap");
        check_replay(2, "wrap");
    endtask

    task automatic test_random_fill();
        for (int k = 0; k < 3; k++) begin
            prepare("rand");
            write_random(int'($urandom_range(1, 20)));
            sync_review("rand");
            check_replay(2, "rand");
        end
    endtask

    task automatic test_single();
        prepare("single");
        write_random(1);
        sync_review("single");
        check_replay(4, "single");
    endtask

    task automatic test_backpressure();
        logic [PT_W-1:0] d;
        logic f, l;
        int unsigned t;
        bit ok;
        int bad;
        prepare("bp");
        write_random(5);
        sync_review("bp");
        wait_beat(d, f, l, t, ok);
        out_ready = 1'b0;
        checks++;
        if (!ok || d !== model_q[0] || f !== 1'b1) begin
            errors++;
            $display("FAIL bp_first: ok=%0d data=%h first=%0d, expected data=%h first=1", ok, d, f, model_q[0]);
        end
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || {out_x, out_y, out_z} !== model_q[0] ||
                out_first !== 1'b1 || out_last !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold: output changed on %0d of 20 stalled cycles, expected 0", bad);
        end
        out_ready = 1'b1;
        wait_beat(d, f, l, t, ok);
        checks++;
        if (!ok || d !== model_q[1] || f !== 1'b0 || l !== 1'b0) begin
            errors++;
            $display("FAIL bp_next: ok=%0d data=%h first=%0d last=%0d, expected data=%h first=0 last=0",
                     ok, d, f, l, model_q[1]);
        end
    endtask

    task automatic test_draw_toggle();
        logic [PT_W-1:0] d;
        logic f, l;
        int unsigned t;
        bit ok;
        prepare("toggle");
        write_random(5);
        sync_review("toggle");
        wait_beat(d, f, l, t, ok);
        wait_beat(d, f, l, t, ok);
        out_ready = 1'b0;
        draw_mode = 1'b1;
        checks++;
        if (!ok || d !== model_q[1]) begin
            errors++;
            $display("FAIL toggle_second: ok=%0d data=%h, expected %h", ok, d, model_q[1]);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || {out_x, out_y, out_z} !== model_q[1]) begin
            errors++;
            $display("FAIL toggle_hold: valid=%0d data=%h, expected valid=1 data=%h",
                     out_valid, {out_x, out_y, out_z}, model_q[1]);
        end
        out_ready = 1'b1;
        wait_beat(d, f, l, t, ok);
        checks++;
        if (!ok || d !== model_q[0] || f !== 1'b1) begin
            errors++;
            $display("FAIL toggle_restart: ok=%0d data=%h first=%0d, expected data=%h first=1",
                     ok, d, f, model_q[0]);
        end
        draw_mode = 1'b0;
    endtask

    task automatic test_clear();
        logic [PT_W-1:0] d;
        logic f, l;
        int unsigned t;
        bit ok;
        int bad;
        prepare("clear");
        write_random(5);
        sync_review("clear");
        wait_beat(d, f, l, t, ok);
        @(posedge clk);
        @(posedge clk);
        #1;
        draw_mode = 1'b1;
        clear_in  = 1'b1;
        in_valid  = 1'b1;
        in_x = X_W'($urandom);
        in_y = Y_W'($urandom);
        in_z = Z_W'($urandom);
        @(posedge clk);
        #1;
        clear_in = 1'b0;
        in_valid = 1'b0;
        model_clear();
        @(negedge clk);
        checks++;
        if (num_points !== '0 || out_valid !== 1'b0 || wr_addr !== '0 || full !== 1'b0) begin
            errors++;
            $display("FAIL clear_state: num=%0d valid=%0d wr_addr=%0d full=%0d, expected all 0",
                     num_points, out_valid, wr_addr, full);
        end
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || num_points !== '0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL clear_stale: activity on %0d cycles after clear, expected 0", bad);
        end
        draw_mode = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [PT_W-1:0] d;
        logic f, l;
        int unsigned t;
        bit ok;
        int bad;
        prepare("arst");
        write_random(3);
        sync_review("arst");
        wait_beat(d, f, l, t, ok);
        out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || num_points !== '0 || full !== 1'b0 || wr_addr !== '0 ||
            out_first !== 1'b0 || out_last !== 1'b0 || {out_x, out_y, out_z} !== '0) begin
            errors++;
            $display("FAIL arst_immediate: valid=%0d num=%0d wr_addr=%0d first=%0d data=%h, expected all zero",
                     out_valid, num_points, wr_addr, out_first, {out_x, out_y, out_z});
        end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || num_points !== '0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL arst_quiet: replay activity on %0d cycles after reset, expected 0", bad);
        end
        draw_mode = 1'b1;
        write_random(2);
        sync_review("arst");
        check_replay(2, "arst");
    endtask

    initial begin
        rst       = 1'b1;
        draw_mode = 1'b0;
        clear_in  = 1'b0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_y      = '0;
        in_z      = '0;
        out_ready = 1'b0;

        test_reset();
        test_basic();
        test_wrap();
        test_random_fill();
        test_single();
        test_backpressure();
        test_draw_toggle();
        test_clear();
        test_async_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
